integ_sched: RTL and testbench

//  Shares one saturating integrator datapath (the PID I-term path) between NUM_CH error sources.

---
 rtl/integ_sched_pkg.sv | 34 +++
 rtl/integ_sched_rr_arbiter.sv | 50 +++++
 rtl/integ_sched.sv | 140 ++++++++++++++
 tb/tb_integ_sched.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/integ_sched_pkg.sv
// Shared types, default widths and the error saturation helper for the
// time-multiplexed PID integrator.
package integ_sched_pkg;

  localparam int NUM_CH_DEF  = 2;
  localparam int RAW_W_DEF   = 16;
  localparam int ERR_W_DEF   = 10;
  localparam int INTEG_W_DEF = 16;
  localparam int I_SHIFT_DEF = 6;
  localparam int I_W_DEF     = 10;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  // Clamp a sign-extended raw error into the signed err_w range; the caller
  // keeps the low err_w bits of the result.
  function automatic logic signed [31:0] sat_err(input logic signed [31:0] raw,
                                                 input int err_w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (err_w - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (raw > hi) begin
      return hi;
    end else if (raw < lo) begin
      return lo;
    end else begin
      return raw;
    end
  endfunction

endpackage

// File: rtl/integ_sched_rr_arbiter.sv
// Round-robin arbiter: the channel after the last granted one has the
// highest priority; the pointer only moves when a grant is taken.
module integ_sched_rr_arbiter #(
  parameter int NUM_CH = 2,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req_i,
  input  logic              advance_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic [CH_W-1:0]   gnt_idx_o
);

  logic [CH_W-1:0] ptr_q;
  logic [CH_W-1:0] ptr_d;
  logic [CH_W-1:0] idx;
  logic            found;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = '0;
    for (int off = 0; off < NUM_CH; off++) begin
      idx = CH_W'((int'(ptr_q) + off) % NUM_CH);
      if (!found && req_i[idx]) begin
        found     = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o = idx;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && found) begin
      ptr_d = (int'(gnt_idx_o) == NUM_CH - 1) ? '0 : gnt_idx_o + CH_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/integ_sched.sv
// One saturating integrator datapath shared round-robin between NUM_CH error
// sources; each grant takes two cycles (IDLE grant, ACC write-back).
module integ_sched
  import integ_sched_pkg::*;
#(
  parameter int NUM_CH  = NUM_CH_DEF,
  parameter int RAW_W   = RAW_W_DEF,
  parameter int ERR_W   = ERR_W_DEF,
  parameter int INTEG_W = INTEG_W_DEF,
  parameter int I_SHIFT = I_SHIFT_DEF,
  parameter int I_W     = I_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    moving,
  input  logic [NUM_CH-1:0]       req,
  input  logic [NUM_CH*RAW_W-1:0] err_raw,
  input  logic [NUM_CH-1:0]       clr,
  output logic [NUM_CH-1:0]       ack,
  output logic [NUM_CH*I_W-1:0]   I_term,
  output logic [NUM_CH-1:0]       I_vld,
  output state_t                  dbg_state_o
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  // Handshake: a requester holds req[i] with err_raw stable until it sees the
  // one-cycle ack[i] pulse, then drops req[i]; a req still high in the cycle
  // after ack is taken as a new sample. I_vld[i] follows ack[i] by one cycle.

  state_t                    state_q, state_d;
  logic [CH_W-1:0]           ch_q, ch_d;
  logic signed [ERR_W-1:0]   err_q, err_d;
  logic signed [INTEG_W-1:0] integ_q [NUM_CH];
  logic signed [INTEG_W-1:0] integ_d [NUM_CH];
  logic [NUM_CH-1:0]         ivld_q;

  logic [NUM_CH-1:0]         gnt;
  logic [CH_W-1:0]           gnt_idx;
  logic                      grant_en;
  logic [RAW_W-1:0]          raw_sel;
  logic signed [ERR_W-1:0]   err_sat;
  logic signed [INTEG_W-1:0] cur;
  logic signed [INTEG_W-1:0] err_ext;
  logic signed [INTEG_W-1:0] sum;
  logic                      ovf;

  assign grant_en = (state_q == IDLE) && (|req);

  integ_sched_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req),
    .advance_i (grant_en),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req) state_d = ACC;
      ACC:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ack = '0;
    if (state_q == ACC) begin
      ack = NUM_CH'(1) << ch_q;
    end
  end

  assign dbg_state_o = state_q;

  always_comb begin
    raw_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt[i]) raw_sel = err_raw[i*RAW_W +: RAW_W];
    end
  end

  assign err_sat = ERR_W'(sat_err(32'(signed'(raw_sel)), ERR_W));
  assign ch_d    = grant_en ? gnt_idx : ch_q;
  assign err_d   = grant_en ? err_sat : err_q;

  // Signed overflow: operands agree in sign but the sum does not.
  assign cur     = integ_q[ch_q];
  assign err_ext = INTEG_W'(err_q);
  assign sum     = cur + err_ext;
  assign ovf     = (cur[INTEG_W-1] == err_ext[INTEG_W-1]) &&
                   (sum[INTEG_W-1] != cur[INTEG_W-1]);

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      integ_d[i] = integ_q[i];
      if (ack[i]) begin
        if (!moving) begin
          integ_d[i] = '0;
        end else if (!ovf) begin
          integ_d[i] = sum;
        end
      end
      if (clr[i]) integ_d[i] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q   <= '0;
      err_q  <= '0;
      ivld_q <= '0;
      for (int i = 0; i < NUM_CH; i++) integ_q[i] <= '0;
    end else begin
      ch_q   <= ch_d;
      err_q  <= err_d;
      ivld_q <= ack;
      for (int i = 0; i < NUM_CH; i++) integ_q[i] <= integ_d[i];
    end
  end

  assign I_vld = ivld_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_iterm
    assign I_term[g*I_W +: I_W] = integ_q[g][I_SHIFT+I_W-1:I_SHIFT];
  end

endmodule

// File: tb/tb_integ_sched.sv
// Bench for integ_sched: directed vector table, arbitration / clear / reset
// sequences and a random phase against an integer reference model.
module tb_integ_sched;
  import integ_sched_pkg::*;

  logic         clk;
  logic         rst_n;
  logic         moving;
  logic [1:0]   req;
  logic [31:0]  err_raw;
  logic [1:0]   clr;
  logic [1:0]   ack;
  logic [19:0]  I_term;
  logic [1:0]   I_vld;
  state_t       dbg_state;

  integ_sched dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .moving      (moving),
    .req         (req),
    .err_raw     (err_raw),
    .clr         (clr),
    .ack         (ack),
    .I_term      (I_term),
    .I_vld       (I_vld),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- model and scoreboard ----------------
  int n_cmp = 0;
  int n_mis = 0;
  int m_integ [2];
  int ptr_m;
  logic [9:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat_m(input logic [15:0] raw);
    int v;
    v = int'($signed(raw));
    if (v > 511) return 511;
    if (v < -512) return -512;
    return v;
  endfunction

  function automatic logic [9:0] iterm_of(input int v);
    int q;
    q = v >>> 6;
    return q[9:0];
  endfunction

  // Integrator is 16-bit signed: an out-of-range sum leaves it unchanged.
  task automatic model_acc(input int ch, input logic [15:0] raw, input logic mov);
    int n;
    if (!mov) begin
      m_integ[ch] = 0;
    end else begin
      n = m_integ[ch] + sat_m(raw);
      if (n <= 32767 && n >= -32768) m_integ[ch] = n;
    end
  endtask

  // ---------------- driver tasks ----------------
  // Entered and left on a negedge while the DUT is IDLE.
  task automatic do_txn(input int ch, input logic [15:0] raw, input logic mov,
                        input logic [1:0] c0, input logic [1:0] c1);
    logic [1:0] oh;
    oh = 2'b01 << ch;
    req = oh;
    err_raw[ch*16 +: 16] = raw;
    moving = mov;
    clr = c0;
    for (int i = 0; i < 2; i++) if (c0[i]) m_integ[i] = 0;
    model_acc(ch, raw, mov);
    for (int i = 0; i < 2; i++) if (c1[i]) m_integ[i] = 0;
    exp_q.push_back(iterm_of(m_integ[ch]));
    ptr_m = (ch + 1) % 2;
    @(negedge clk);
    check("ack", {30'd0, ack}, {30'd0, oh});
    check("ivld_during_acc", {30'd0, I_vld}, 32'd0);
    req = 2'b00;
    clr = c1;
    @(negedge clk);
    clr = 2'b00;
    check("ivld", {30'd0, I_vld}, {30'd0, oh});
    check("iterm_serviced", {22'd0, I_term[ch*10 +: 10]}, {22'd0, exp_q.pop_front()});
    check("iterm_other", {22'd0, I_term[(1-ch)*10 +: 10]}, {22'd0, iterm_of(m_integ[1-ch])});
  endtask

  task automatic clear_all();
    clr = 2'b11;
    m_integ[0] = 0;
    m_integ[1] = 0;
    @(negedge clk);
    clr = 2'b00;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int         ch;
    logic [15:0] raw;
    int         reps;
    logic [9:0] exp_iterm;
  } vec_t;

  vec_t vecs [14];

  int          grants;
  int          exp_ch;
  logic [1:0]  prev_ack;
  int          r_ch;
  logic [15:0] r_raw;
  logic        r_mov;
  logic [1:0]  r_c0;
  logic [1:0]  r_c1;

  initial begin
    vecs[0]  = '{0, 16'h01FF, 10, 10'h04F};
    vecs[1]  = '{1, 16'h0200, 10, 10'h04F};
    vecs[2]  = '{0, 16'h7FFF, 64, 10'h1FF};
    vecs[3]  = '{0, 16'h7FFF, 65, 10'h1FF};
    vecs[4]  = '{0, 16'h8000, 64, 10'h200};
    vecs[5]  = '{1, 16'h8000, 65, 10'h200};
    vecs[6]  = '{0, 16'hFE00, 10, 10'h3B0};
    vecs[7]  = '{1, 16'hFDFF, 10, 10'h3B0};
    vecs[8]  = '{0, 16'h0100, 3,  10'h00C};
    vecs[9]  = '{1, 16'hFF00, 3,  10'h3F4};
    vecs[10] = '{0, 16'h0040, 1,  10'h001};
    vecs[11] = '{1, 16'hFFC1, 1,  10'h3FF};
    vecs[12] = '{1, 16'h0201, 1,  10'h007};
    vecs[13] = '{0, 16'h003F, 1,  10'h000};

    // Reset with both channels requesting
    rst_n = 1'b0;
    req = 2'b11;
    err_raw = '0;
    moving = 1'b1;
    clr = 2'b00;
    m_integ[0] = 0;
    m_integ[1] = 0;
    ptr_m = 0;
    repeat (2) @(negedge clk);
    check("rst_ack", {30'd0, ack}, 32'd0);
    check("rst_ivld", {30'd0, I_vld}, 32'd0);
    check("rst_iterm", {12'd0, I_term}, 32'd0);
    check("rst_state", {31'd0, dbg_state}, {31'd0, IDLE});
    rst_n = 1'b1;
    @(negedge clk);
    check("first_ack_ch0", {30'd0, ack}, 32'd1);
    req = 2'b00;
    ptr_m = 1;
    @(negedge clk);
    check("first_ivld_ch0", {30'd0, I_vld}, 32'd1);
    check("first_iterm", {12'd0, I_term}, 32'd0);

    // Directed table
    foreach (vecs[v]) begin
      clear_all();
      for (int k = 0; k < vecs[v].reps; k++) do_txn(vecs[v].ch, vecs[v].raw, 1'b1, 2'b00, 2'b00);
      check("vec_iterm", {22'd0, I_term[vecs[v].ch*10 +: 10]}, {22'd0, vecs[v].exp_iterm});
      check("vec_other_zero", {22'd0, I_term[(1-vecs[v].ch)*10 +: 10]}, 32'd0);
    end

    // Arbitration: both channels keep requesting, each drops only on its ack
    clear_all();
    err_raw = {16'hFFC0, 16'h0040};
    moving = 1'b1;
    req = 2'b11;
    exp_ch = ptr_m;
    grants = 0;
    prev_ack = 2'b00;
    for (int cyc = 0; cyc < 40 && grants < 6; cyc++) begin
      @(negedge clk);
      check("arb_ivld", {30'd0, I_vld}, {30'd0, prev_ack});
      if (ack != 2'b00) begin
        check("arb_ack", {30'd0, ack}, 32'd1 << exp_ch);
        model_acc(exp_ch, err_raw[exp_ch*16 +: 16], 1'b1);
        exp_ch = 1 - exp_ch;
        grants++;
      end
      prev_ack = ack;
      req = ~ack;
    end
    req = 2'b00;
    check("arb_grants", grants, 6);
    @(negedge clk);
    check("arb_ivld_last", {30'd0, I_vld}, {30'd0, prev_ack});
    check("arb_iterm0", {22'd0, I_term[9:0]}, {22'd0, iterm_of(m_integ[0])});
    check("arb_iterm1", {22'd0, I_term[19:10]}, {22'd0, iterm_of(m_integ[1])});
    ptr_m = exp_ch;

    // moving=0 on ch1, clr[0] coinciding with ch0 write-back
    clear_all();
    for (int k = 0; k < 4; k++) do_txn(1, 16'h0100, 1'b1, 2'b00, 2'b00);
    check("pre_moving_iterm1", {22'd0, I_term[19:10]}, {22'd0, 10'h010});
    do_txn(1, 16'h0100, 1'b0, 2'b00, 2'b00);
    check("moving0_iterm1", {22'd0, I_term[19:10]}, 32'd0);
    for (int k = 0; k < 4; k++) do_txn(0, 16'h0100, 1'b1, 2'b00, 2'b00);
    do_txn(0, 16'h0100, 1'b1, 2'b00, 2'b01);
    check("clr_wins_iterm0", {22'd0, I_term[9:0]}, 32'd0);

    // Randomized phase against the model
    clear_all();
    for (int t = 0; t < 200; t++) begin
      r_ch = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0:       r_raw = 16'(int'($urandom_range(0, 1200)) - 600);
        1:       r_raw = ($urandom_range(0, 3) != 0) ? 16'h7FFF : 16'h8000;
        2:       r_raw = 16'($urandom);
        default: r_raw = ($urandom_range(0, 1) != 0) ? 16'h0200 : 16'hFDFF;
      endcase
      r_mov = ($urandom_range(0, 7) != 0);
      r_c0 = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      r_c1 = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      do_txn(r_ch, r_raw, r_mov, r_c0, r_c1);
    end

    // Reset during ACC drops the in-flight sample
    do_txn(1, 16'h7FFF, 1'b1, 2'b00, 2'b00);
    req = 2'b10;
    err_raw[31:16] = 16'h0100;
    @(negedge clk);
    check("mid_acc_state", {31'd0, dbg_state}, {31'd0, ACC});
    rst_n = 1'b0;
    req = 2'b00;
    #1;
    check("mid_rst_ack", {30'd0, ack}, 32'd0);
    check("mid_rst_ivld", {30'd0, I_vld}, 32'd0);
    @(negedge clk);
    check("mid_rst_iterm", {12'd0, I_term}, 32'd0);
    check("mid_rst_state", {31'd0, dbg_state}, {31'd0, IDLE});
    rst_n = 1'b1;
    m_integ[0] = 0;
    m_integ[1] = 0;
    ptr_m = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_rst_ivld", {30'd0, I_vld}, 32'd0);
      check("post_rst_state", {31'd0, dbg_state}, {31'd0, IDLE});
    end
    check("post_rst_iterm", {12'd0, I_term}, 32'd0);
    req = 2'b11;
    @(negedge clk);
    check("post_rst_ptr_ch0", {30'd0, ack}, 32'd1);
    req = 2'b00;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
